vid_pattern_gen: RTL and testbench

VID_PATTERN_GEN -- requirements
Module: vid_pattern_gen

---
 rtl/vid_pattern_gen.sv | 270 +++++++++++++++++++++++++++
 tb/tb_vid_pattern_gen.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vid_pattern_gen.sv
// -----------------------------------------------------------------------------
// vid_pattern_gen
//
// Video timing and test-pattern generator. A pair of 12-bit raster counters
// (h_cnt, v_cnt) walks the full frame, including blanking. From the counter
// state the block derives active video, horizontal/vertical sync and one of
// four test patterns. Every output is registered, so all outputs lag the
// counter state by exactly one clock and stay mutually aligned.
//
// Run control is a small FSM:
//   IDLE  : counters parked at 0,0; outputs idle.
//   RUN   : counters free-run across frame boundaries.
//   DRAIN : en was dropped. The current frame is finished and then the FSM
//           parks in IDLE. If en returns first, the FSM goes back to RUN
//           without disturbing the raster.
//
// Parameters
//   H_ACTIVE/H_FP/H_SYNC/H_BP : horizontal timing in pixels (H_ACTIVE % 8 == 0)
//   V_ACTIVE/V_FP/V_SYNC/V_BP : vertical timing in lines
//   HS_POL/VS_POL             : level of the sync pulse while it is asserted
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   en           in   run request
//   sw[7:0]      in   pattern control, sampled once per frame
//                     [1:0] mode: 00 solid, 01 bars, 10 ramp, 11 checker
//                     [2]   invert rgb inside the active region
//                     [4:3] unused
//                     [7:5] solid colour r/g/b
//   tx_red/green/blue[7:0] out  pixel data, 0 outside active video
//   tx_dv        out  active video
//   tx_hs        out  horizontal sync
//   tx_vs        out  vertical sync
//   frame_start  out  one-cycle pulse on the first pixel of each frame
// -----------------------------------------------------------------------------
module vid_pattern_gen #(
    parameter int   H_ACTIVE = 1920,
    parameter int   H_FP     = 88,
    parameter int   H_SYNC   = 44,
    parameter int   H_BP     = 148,
    parameter int   V_ACTIVE = 1080,
    parameter int   V_FP     = 4,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 36,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] sw,
    output logic [7:0] tx_red,
    output logic [7:0] tx_green,
    output logic [7:0] tx_blue,
    output logic       tx_dv,
    output logic       tx_hs,
    output logic       tx_vs,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT      = 12'(V_ACTIVE);
    localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_START   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END     = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] BAR_LAST   = 12'(H_ACTIVE / 8 - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic [11:0] bar_pix_q, bar_pix_d;
    logic [2:0]  bar_k_q, bar_k_d;
    logic [7:0]  sw_q, sw_d;

    logic [7:0]  red_d, green_d, blue_d;
    logic        dv_d, hs_d, vs_d, fs_d;

    logic        running;
    logic        line_end;
    logic        frame_end;
    logic        frame_first;
    logic        active;
    logic [7:0]  sw_cur;
    logic [7:0]  pat_r, pat_g, pat_b;
    logic        checker_on;
    logic        unused_sw;

    assign running     = (state_q != ST_IDLE);
    assign line_end    = (h_cnt_q == H_LAST);
    assign frame_end   = line_end && (v_cnt_q == V_LAST);
    assign frame_first = running && (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    assign active      = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

    // The pixel at 0,0 is the one that latches sw, so it must already be
    // rendered with the new settings; every later pixel uses the latched copy.
    assign sw_cur     = frame_first ? sw : sw_q;
    assign checker_on = h_cnt_q[4] ^ v_cnt_q[4];
    assign unused_sw  = ^sw_cur[4:3];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!en) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Re-request wins over the end-of-frame park so the raster
                // keeps running without a restart.
                if (en)             state_d = ST_RUN;
                else if (frame_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Raster counters, bar counter and sw latch (next-state)
    // ------------------------------------------------------------------
    always_comb begin
        h_cnt_d   = 12'd0;
        v_cnt_d   = 12'd0;
        bar_pix_d = 12'd0;
        bar_k_d   = 3'd0;
        sw_d      = sw_q;

        if (running) begin
            if (line_end) begin
                h_cnt_d = 12'd0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
            end else begin
                h_cnt_d = h_cnt_q + 12'd1;
                v_cnt_d = v_cnt_q;
            end

            // Bar index advances every H_ACTIVE/8 pixels and saturates at 7
            // through the blanking; it restarts with each new line.
            if (!line_end) begin
                if (bar_pix_q == BAR_LAST) begin
                    bar_pix_d = 12'd0;
                    bar_k_d   = (bar_k_q == 3'd7) ? 3'd7 : bar_k_q + 3'd1;
                end else begin
                    bar_pix_d = bar_pix_q + 12'd1;
                    bar_k_d   = bar_k_q;
                end
            end
        end

        if (frame_first || (state_q == ST_IDLE && en)) begin
            sw_d = sw;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q   <= 12'd0;
            v_cnt_q   <= 12'd0;
            bar_pix_q <= 12'd0;
            bar_k_q   <= 3'd0;
            sw_q      <= 8'd0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            bar_pix_q <= bar_pix_d;
            bar_k_q   <= bar_k_d;
            sw_q      <= sw_d;
        end
    end

    // ------------------------------------------------------------------
    // Pattern generation
    // ------------------------------------------------------------------
    always_comb begin
        pat_r = 8'd0;
        pat_g = 8'd0;
        pat_b = 8'd0;
        case (sw_cur[1:0])
            2'b00: begin
                pat_r = {8{sw_cur[7]}};
                pat_g = {8{sw_cur[6]}};
                pat_b = {8{sw_cur[5]}};
            end
            2'b01: begin
                pat_r = {8{bar_k_q[2]}};
                pat_g = {8{bar_k_q[1]}};
                pat_b = {8{bar_k_q[0]}};
            end
            2'b10: begin
                pat_r = h_cnt_q[7:0];
                pat_g = h_cnt_q[7:0];
                pat_b = h_cnt_q[7:0];
            end
            default: begin
                pat_r = {8{checker_on}};
                pat_g = {8{checker_on}};
                pat_b = {8{checker_on}};
            end
        endcase
        if (sw_cur[2]) begin
            pat_r = ~pat_r;
            pat_g = ~pat_g;
            pat_b = ~pat_b;
        end
    end

    // ------------------------------------------------------------------
    // FSM: output logic (values registered on the next edge)
    // ------------------------------------------------------------------
    always_comb begin
        dv_d    = running && active;
        // Gating by dv keeps rgb at zero in blanking, which also confines
        // the inversion to the active region.
        red_d   = dv_d ? pat_r : 8'd0;
        green_d = dv_d ? pat_g : 8'd0;
        blue_d  = dv_d ? pat_b : 8'd0;
        hs_d    = (running && h_cnt_q >= HS_START && h_cnt_q < HS_END) ? HS_POL : ~HS_POL;
        vs_d    = (running && v_cnt_q >= VS_START && v_cnt_q < VS_END) ? VS_POL : ~VS_POL;
        fs_d    = frame_first;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_red      <= 8'd0;
            tx_green    <= 8'd0;
            tx_blue     <= 8'd0;
            tx_dv       <= 1'b0;
            tx_hs       <= ~HS_POL;
            tx_vs       <= ~VS_POL;
            frame_start <= 1'b0;
        end else begin
            tx_red      <= red_d;
            tx_green    <= green_d;
            tx_blue     <= blue_d;
            tx_dv       <= dv_d;
            tx_hs       <= hs_d;
            tx_vs       <= vs_d;
            frame_start <= fs_d;
        end
    end

endmodule

// File: tb/tb_vid_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_vid_pattern_gen
//
// Small-raster bench: 16x4 active, 24x8 total, 192 cycles per frame.
// A behavioural reference model predicts the registered outputs for each
// clock; the prediction is queued when the inputs for that edge are driven
// and compared after the edge. Scenario tasks add direct checks on timing,
// patterns, sw latching, drain behaviour and reset.
// -----------------------------------------------------------------------------
module tb_vid_pattern_gen;

    localparam int W = 28; // {frame_start, dv, hs, vs, r, g, b}

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] sw;
    logic [7:0] tx_red, tx_green, tx_blue;
    logic       tx_dv, tx_hs, tx_vs, frame_start;

    vid_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .sw          (sw),
        .tx_red      (tx_red),
        .tx_green    (tx_green),
        .tx_blue     (tx_blue),
        .tx_dv       (tx_dv),
        .tx_hs       (tx_hs),
        .tx_vs       (tx_vs),
        .frame_start (frame_start)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [W-1:0] exp_q[$];

    logic [23:0] bar_tab [8] = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                                 24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};

    // Reference model state: st 0=idle 1=run 2=drain
    int         m_st = 0;
    int         m_h  = 0;
    int         m_v  = 0;
    logic [7:0] m_sw = 8'd0;

    function automatic logic [W-1:0] dut_obs();
        return {frame_start, tx_dv, tx_hs, tx_vs, tx_red, tx_green, tx_blue};
    endfunction

    function automatic logic [W-1:0] model_out();
        logic       running, first, active, hs, vs;
        logic [7:0] s, r, g, b;
        int         k;
        running = (m_st != 0);
        first   = running && m_h == 0 && m_v == 0;
        s       = first ? sw : m_sw;
        active  = running && m_h < 16 && m_v < 4;
        hs      = running && m_h >= 18 && m_h <= 20;
        vs      = running && m_v >= 5 && m_v <= 6;
        r = 8'h00; g = 8'h00; b = 8'h00;
        if (active) begin
            case (s[1:0])
                2'd0: begin
                    r = s[7] ? 8'hFF : 8'h00;
                    g = s[6] ? 8'hFF : 8'h00;
                    b = s[5] ? 8'hFF : 8'h00;
                end
                2'd1: begin
                    k = m_h / 2;
                    r = (k & 4) != 0 ? 8'hFF : 8'h00;
                    g = (k & 2) != 0 ? 8'hFF : 8'h00;
                    b = (k & 1) != 0 ? 8'hFF : 8'h00;
                end
                2'd2: begin
                    r = 8'(m_h); g = r; b = r;
                end
                default: begin
                    r = ((((m_h / 16) ^ (m_v / 16)) & 1) != 0) ? 8'hFF : 8'h00;
                    g = r; b = r;
                end
            endcase
            if (s[2]) begin
                r = ~r; g = ~g; b = ~b;
            end
        end
        return {first, active, hs, vs, r, g, b};
    endfunction

    task automatic model_step();
        int   st_old;
        logic wrap;
        st_old = m_st;
        wrap   = (m_h == 23 && m_v == 7);
        if ((st_old != 0 && m_h == 0 && m_v == 0) || (st_old == 0 && en)) m_sw = sw;
        case (st_old)
            0:       if (en) m_st = 1;
            1:       if (!en) m_st = 2;
            default: if (en) m_st = 1; else if (wrap) m_st = 0;
        endcase
        if (st_old == 0) begin
            m_h = 0; m_v = 0;
        end else if (m_h == 23) begin
            m_h = 0;
            m_v = (m_v == 7) ? 0 : m_v + 1;
        end else begin
            m_h = m_h + 1;
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_h = 0; m_v = 0; m_sw = 8'd0;
        exp_q.delete();
    endtask

    // Driver: queue the prediction for the coming edge, clock, update model.
    task automatic tick();
        exp_q.push_back(model_out());
        @(posedge clk);
        model_step();
        #1;
        cyc++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; sw = 8'd0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (dut_obs() !== '0) $display("FAIL reset_idle got=%h exp=%h", dut_obs(), {W{1'b0}});
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
    endtask

    task automatic test_timing();
        logic [W-1:0] exp_v;
        int last_fs = -1, dv_c = 0, hs_c = 0, vs_c = 0, off, gaps = 0;
        for (int i = 0; i < 2 * 192 + 10; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            n_checks++;
            if (dut_obs() !== exp_v) $display("FAIL sb_timing cyc=%0d got=%h exp=%h", cyc, dut_obs(), exp_v);
            else n_pass++;
            if (frame_start) begin
                if (last_fs >= 0) begin
                    gaps++;
                    n_checks++;
                    if (cyc - last_fs != 192) $display("FAIL fs_period got=%0d exp=192", cyc - last_fs);
                    else n_pass++;
                    n_checks++;
                    if (dv_c != 64 || hs_c != 24 || vs_c != 48)
                        $display("FAIL frame_counts got dv=%0d hs=%0d vs=%0d exp dv=64 hs=24 vs=48", dv_c, hs_c, vs_c);
                    else n_pass++;
                end
                last_fs = cyc; dv_c = 0; hs_c = 0; vs_c = 0;
            end
            if (last_fs >= 0) begin
                off = cyc - last_fs;
                dv_c += int'(tx_dv); hs_c += int'(tx_hs); vs_c += int'(tx_vs);
                if (tx_hs) begin
                    n_checks++;
                    if (off % 24 < 18 || off % 24 > 20) $display("FAIL hs_pos got=%0d exp=18..20", off % 24);
                    else n_pass++;
                end
                if (tx_dv) begin
                    n_checks++;
                    if (off % 24 >= 16 || off / 24 >= 4) $display("FAIL dv_pos got=%0d,%0d exp=<16,<4", off % 24, off / 24);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (gaps != 2) $display("FAIL fs_seen got=%0d exp=2", gaps);
        else n_pass++;
    endtask

    task automatic test_bars();
        logic [W-1:0] exp_v;
        int nfs = 0, fs_c = 0, off, n_px = 0;
        sw = 8'b000_00_001;
        for (int i = 0; i < 500 && nfs < 2; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            n_checks++;
            if (dut_obs() !== exp_v) $display("FAIL sb_bars cyc=%0d got=%h exp=%h", cyc, dut_obs(), exp_v);
            else n_pass++;
            if (frame_start) begin nfs++; fs_c = cyc; end
            if (nfs == 1 && tx_dv) begin
                off = (cyc - fs_c) % 24;
                n_px++;
                n_checks++;
                if ({tx_red, tx_green, tx_blue} !== bar_tab[off / 2])
                    $display("FAIL bar_colour px=%0d got=%h exp=%h", off, {tx_red, tx_green, tx_blue}, bar_tab[off / 2]);
                else n_pass++;
            end
        end
        n_checks++;
        if (n_px != 64) $display("FAIL bar_pixels got=%0d exp=64", n_px);
        else n_pass++;
    endtask

    task automatic test_ramp_inv();
        logic [W-1:0] exp_v;
        logic [7:0]   e;
        int nfs = 0, fs_c = 0, off;
        sw = 8'b000_00_110;
        for (int i = 0; i < 500 && nfs < 2; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            n_checks++;
            if (dut_obs() !== exp_v) $display("FAIL sb_ramp cyc=%0d got=%h exp=%h", cyc, dut_obs(), exp_v);
            else n_pass++;
            if (frame_start) begin nfs++; fs_c = cyc; end
            if (nfs == 1) begin
                off = (cyc - fs_c) % 24;
                e   = tx_dv ? 8'(255 - off) : 8'h00;
                n_checks++;
                if (tx_red !== e || tx_green !== e || tx_blue !== e)
                    $display("FAIL ramp_inv px=%0d got=%h%h%h exp=%h", off, tx_red, tx_green, tx_blue, e);
                else n_pass++;
            end
        end
        n_checks++;
        if (nfs != 2) $display("FAIL ramp_frames got=%0d exp=2", nfs);
        else n_pass++;
    endtask

    task automatic test_sw_midframe();
        logic [W-1:0] exp_v;
        int nfs = 0, fs_c = 0;
        sw = 8'h00;
        for (int i = 0; i < 700 && nfs < 3; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            n_checks++;
            if (dut_obs() !== exp_v) $display("FAIL sb_swmid cyc=%0d got=%h exp=%h", cyc, dut_obs(), exp_v);
            else n_pass++;
            if (frame_start) begin nfs++; fs_c = cyc; end
            if (nfs == 1 && tx_dv) begin
                n_checks++;
                if ({tx_red, tx_green, tx_blue} !== 24'h000000)
                    $display("FAIL swmid_black got=%h exp=000000", {tx_red, tx_green, tx_blue});
                else n_pass++;
            end
            if (nfs == 2 && tx_dv) begin
                n_checks++;
                if ({tx_red, tx_green, tx_blue} !== 24'hFFFFFF)
                    $display("FAIL swmid_white got=%h exp=FFFFFF", {tx_red, tx_green, tx_blue});
                else n_pass++;
            end
            if (nfs == 1 && cyc - fs_c == 48) sw = 8'hE0;
        end
        n_checks++;
        if (nfs != 3) $display("FAIL swmid_frames got=%0d exp=3", nfs);
        else n_pass++;
    endtask

    task automatic test_drain();
        logic [W-1:0] exp_v;
        int nfs = 0, fs_c = 0, off = 0, gap = -1;
        sw = 8'h01;
        // Part 1: drop en on line 1, frame must finish and then go idle.
        for (int i = 0; i < 500 && off < 215; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            n_checks++;
            if (dut_obs() !== exp_v) $display("FAIL sb_drain cyc=%0d got=%h exp=%h", cyc, dut_obs(), exp_v);
            else n_pass++;
            if (frame_start) begin nfs++; fs_c = cyc; end
            if (nfs >= 1) begin
                off = cyc - fs_c;
                if (off == 24) en = 1'b0;
                if (off == 191) begin
                    n_checks++;
                    if (tx_dv !== 1'b0 || tx_vs !== 1'b0 || tx_hs !== 1'b0)
                        $display("FAIL drain_last got=%b%b%b exp=000", tx_dv, tx_hs, tx_vs);
                    else n_pass++;
                end
                if (off >= 192) begin
                    n_checks++;
                    if (dut_obs() !== '0) $display("FAIL drain_idle off=%0d got=%h exp=0", off, dut_obs());
                    else n_pass++;
                end
            end
        end
        // Part 2: short en glitch must not disturb the frame period.
        en = 1'b1; nfs = 0;
        for (int i = 0; i < 700 && nfs < 2; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            n_checks++;
            if (dut_obs() !== exp_v) $display("FAIL sb_glitch cyc=%0d got=%h exp=%h", cyc, dut_obs(), exp_v);
            else n_pass++;
            if (frame_start) begin
                nfs++;
                if (nfs == 2) gap = cyc - fs_c;
                fs_c = cyc;
            end
            if (nfs == 1 && cyc - fs_c == 24) en = 1'b0;
            if (nfs == 1 && cyc - fs_c == 29) en = 1'b1;
        end
        n_checks++;
        if (gap != 192) $display("FAIL glitch_period got=%0d exp=192", gap);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        logic [W-1:0] exp_v;
        int nfs = 0, fs_c = 0, first_fs = -1, gap = -1;
        sw = 8'hE0;
        for (int i = 0; i < 500; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            n_checks++;
            if (dut_obs() !== exp_v) $display("FAIL sb_prerst cyc=%0d got=%h exp=%h", cyc, dut_obs(), exp_v);
            else n_pass++;
            if (frame_start) begin nfs++; fs_c = cyc; end
            if (nfs >= 1 && cyc - fs_c == 3 * 24 + 5) break;
        end
        n_checks++;
        if (tx_dv !== 1'b1) $display("FAIL prerst_active got=%b exp=1", tx_dv);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_obs() !== '0) $display("FAIL rst_async got=%h exp=0", dut_obs());
        else n_pass++;
        model_reset();
        @(posedge clk); #1;
        n_checks++;
        if (dut_obs() !== '0) $display("FAIL rst_hold got=%h exp=0", dut_obs());
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        nfs = 0;
        for (int i = 1; i <= 400 && nfs < 2; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            n_checks++;
            if (dut_obs() !== exp_v) $display("FAIL sb_postrst cyc=%0d got=%h exp=%h", cyc, dut_obs(), exp_v);
            else n_pass++;
            if (frame_start) begin
                nfs++;
                if (nfs == 1) first_fs = i;
                else gap = cyc - fs_c;
                fs_c = cyc;
            end
        end
        n_checks++;
        if (first_fs != 2) $display("FAIL rst_first_fs got=%0d exp=2", first_fs);
        else n_pass++;
        n_checks++;
        if (gap != 192) $display("FAIL rst_period got=%0d exp=192", gap);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [W-1:0] exp_v;
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 99) < 4)  sw = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 99) < 2)  en = ~en;
            tick();
            exp_v = exp_q.pop_front();
            n_checks++;
            if (dut_obs() !== exp_v) $display("FAIL sb_random cyc=%0d got=%h exp=%h", cyc, dut_obs(), exp_v);
            else n_pass++;
        end
        en = 1'b1;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_timing();
        test_bars();
        test_ramp_inv();
        test_sw_midframe();
        test_drain();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
